fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 84 ++++++++
 tb/tb_fetch_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Fetch-stage control FSM: steers PC redirects, flushes, stalls and halt for a
// simple in-order pipeline. All outputs are Moore-decoded from the state register.
module fetch_controller #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              load_use,
  input  logic              mem_busy,
  input  logic              halt_ins,
  input  logic              resume,
  output logic              pc_mux_sel,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              stall,
  output logic              stall_pm,
  output logic              flush,
  output logic              halted,
  output logic [CNT_W-1:0]  redirect_count
);

  localparam logic [2:0] RUN      = 3'd0;
  localparam logic [2:0] REDIR    = 3'd1;
  localparam logic [2:0] FLUSH    = 3'd2;
  localparam logic [2:0] LU_STALL = 3'd3;
  localparam logic [2:0] MEM_WAIT = 3'd4;
  localparam logic [2:0] HALT     = 3'd5;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [ADDR_W-1:0] tgt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              take_redirect;

  // Only RUN looks at hazards; every other state belongs to a squashed or held slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (br_taken || jmp)  state_d = REDIR;
        else if (mem_busy)    state_d = MEM_WAIT;
        else if (load_use)    state_d = LU_STALL;
        else if (halt_ins)    state_d = HALT;
        else                  state_d = RUN;
      end
      REDIR:    state_d = FLUSH;
      FLUSH:    state_d = mem_busy ? MEM_WAIT : RUN;
      LU_STALL: state_d = RUN;
      MEM_WAIT: state_d = mem_busy ? MEM_WAIT : RUN;
      HALT:     state_d = resume ? RUN : HALT;
      default:  state_d = RUN;
    endcase
  end

  assign take_redirect = (state_q == RUN) && (br_taken || jmp);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take_redirect) begin
        tgt_q <= br_taken ? br_target : jmp_target;
        // Saturate rather than wrap so a long run never reads as few redirects.
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pc_mux_sel     = (state_q == REDIR);
  assign flush          = (state_q == REDIR) || (state_q == FLUSH);
  assign stall          = (state_q == LU_STALL) || (state_q == MEM_WAIT) || (state_q == HALT);
  assign stall_pm       = stall;
  assign halted         = (state_q == HALT);
  assign jmp_loc        = tgt_q;
  assign redirect_count = cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a phase-counter reference model queues
// expected outputs per stimulus cycle; a monitor pops and compares after each edge.
module tb_fetch_controller;

  typedef struct packed {
    logic        reset;
    logic        br_taken;
    logic [15:0] br_target;
    logic        jmp;
    logic [15:0] jmp_target;
    logic        load_use;
    logic        mem_busy;
    logic        halt_ins;
    logic        resume;
  } stim_t;

  typedef struct packed {
    logic        pc_mux_sel;
    logic [15:0] jmp_loc;
    logic        stall;
    logic        stall_pm;
    logic        flush;
    logic        halted;
    logic [7:0]  redirect_count;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = '0;
  logic        jmp = 1'b0;
  logic [15:0] jmp_target = '0;
  logic        load_use = 1'b0;
  logic        mem_busy = 1'b0;
  logic        halt_ins = 1'b0;
  logic        resume = 1'b0;
  logic        pc_mux_sel;
  logic [15:0] jmp_loc;
  logic        stall;
  logic        stall_pm;
  logic        flush;
  logic        halted;
  logic [7:0]  redirect_count;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];

  // Reference model: redirect shadow length, pending stalls and halt as separate facts.
  int          m_redir_left = 0;
  bit          m_lu = 0;
  bit          m_mem = 0;
  bit          m_halt = 0;
  logic [15:0] m_tgt = '0;
  int          m_cnt = 0;

  fetch_controller #(.ADDR_W(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target),
    .load_use(load_use), .mem_busy(mem_busy),
    .halt_ins(halt_ins), .resume(resume),
    .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc),
    .stall(stall), .stall_pm(stall_pm), .flush(flush),
    .halted(halted), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic model_step(input stim_t s);
    if (s.reset) begin
      m_redir_left = 0; m_lu = 0; m_mem = 0; m_halt = 0; m_tgt = '0; m_cnt = 0;
    end else if (m_redir_left == 2) begin
      m_redir_left = 1;
    end else if (m_redir_left == 1) begin
      m_redir_left = 0;
      m_mem = s.mem_busy;
    end else if (m_lu) begin
      m_lu = 0;
    end else if (m_mem) begin
      m_mem = s.mem_busy;
    end else if (m_halt) begin
      m_halt = !s.resume;
    end else if (s.br_taken || s.jmp) begin
      m_redir_left = 2;
      m_tgt = s.br_taken ? s.br_target : s.jmp_target;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end else if (s.mem_busy) begin
      m_mem = 1;
    end else if (s.load_use) begin
      m_lu = 1;
    end else if (s.halt_ins) begin
      m_halt = 1;
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.pc_mux_sel     = (m_redir_left == 2);
    e.jmp_loc        = m_tgt;
    e.flush          = (m_redir_left != 0);
    e.stall          = m_lu || m_mem || m_halt;
    e.stall_pm       = m_lu || m_mem || m_halt;
    e.halted         = m_halt;
    e.redirect_count = m_cnt[7:0];
    return e;
  endfunction

  task automatic apply_stimulus(input stim_t s);
    @(negedge clk);
    reset      = s.reset;
    br_taken   = s.br_taken;
    br_target  = s.br_target;
    jmp        = s.jmp;
    jmp_target = s.jmp_target;
    load_use   = s.load_use;
    mem_busy   = s.mem_busy;
    halt_ins   = s.halt_ins;
    resume     = s.resume;
    model_step(s);
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(idle());
  endtask

  task automatic check_output(input exp_t e);
    exp_t got;
    got = {pc_mux_sel, jmp_loc, stall, stall_pm, flush, halted, redirect_count};
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("[TB] FAIL outputs vec %0d: got pc_mux_sel=%b jmp_loc=%h stall=%b stall_pm=%b flush=%b halted=%b cnt=%0d, required pc_mux_sel=%b jmp_loc=%h stall=%b stall_pm=%b flush=%b halted=%b cnt=%0d",
               vectors, got.pc_mux_sel, got.jmp_loc, got.stall, got.stall_pm, got.flush, got.halted, got.redirect_count,
               e.pc_mux_sel, e.jmp_loc, e.stall, e.stall_pm, e.flush, e.halted, e.redirect_count);
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check_output(exp_q.pop_front());
    end
  end

  initial begin : stimulus
    stim_t s;
    int drain;

    // Reset then quiet pipeline.
    s = idle(); s.reset = 1'b1;
    apply_stimulus(s);
    idle_cycles(5);

    // Branch beats a simultaneous jump.
    s = idle(); s.br_taken = 1'b1; s.br_target = 16'h0008; s.jmp = 1'b1; s.jmp_target = 16'h0020;
    apply_stimulus(s);
    idle_cycles(3);

    // Load-use stall, then a three-cycle memory wait.
    s = idle(); s.load_use = 1'b1;
    apply_stimulus(s);
    idle_cycles(2);
    s = idle(); s.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(s);
    idle_cycles(2);

    // Halt ignores redirects until resume.
    s = idle(); s.halt_ins = 1'b1;
    apply_stimulus(s);
    for (int i = 0; i < 10; i++) begin
      s = idle(); s.br_taken = i[0]; s.br_target = 16'h1234;
      apply_stimulus(s);
    end
    s = idle(); s.resume = 1'b1;
    apply_stimulus(s);
    idle_cycles(2);

    // Counter saturation over 300 spaced jumps.
    s = idle(); s.reset = 1'b1;
    apply_stimulus(s);
    for (int i = 0; i < 300; i++) begin
      s = idle(); s.jmp = 1'b1; s.jmp_target = 16'($urandom);
      apply_stimulus(s);
      idle_cycles(2);
    end
    idle_cycles(2);

    // Reset while in REDIR aborts the flush.
    s = idle(); s.jmp = 1'b1; s.jmp_target = 16'h0008;
    apply_stimulus(s);
    s = idle(); s.reset = 1'b1;
    apply_stimulus(s);
    idle_cycles(3);

    // Randomised mix of hazards, redirects and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      s.reset      = ($urandom_range(63) == 0);
      s.br_taken   = ($urandom_range(5) == 0);
      s.br_target  = 16'($urandom);
      s.jmp        = ($urandom_range(5) == 0);
      s.jmp_target = 16'($urandom);
      s.load_use   = ($urandom_range(4) == 0);
      s.mem_busy   = ($urandom_range(3) == 0);
      s.halt_ins   = ($urandom_range(15) == 0);
      s.resume     = ($urandom_range(7) == 0);
      apply_stimulus(s);
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
